// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot memory loader: FSM state codes, error flag
// bit positions and the width of one buffered FIFO word.
package boot_loader_pkg;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam int ERR_OVERFLOW   = 0;
    localparam int ERR_ADDR_RANGE = 1;
    localparam int ERR_LATE       = 2;

    localparam int WORD_BITS = 32;

    // FIFO entry layout is {ram_id, addr, data}.
    function automatic int fifo_entry_width(input int addr_bits);
        return 1 + addr_bits + WORD_BITS;
    endfunction

endpackage

// File: rtl/boot_word_fifo.sv
// Small synchronous FIFO holding loader words; supports push and pop in the
// same cycle, including a push while full when a pop frees the slot.
module boot_word_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage is pure datapath; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/boot_mem_loader.sv
// Boot loader: buffers UART-assembled words, writes IM/DM, then releases the CPU.
// Optional BOOT_CHECKSUM_EN macro adds a running sum of accepted words.
module boot_mem_loader
    import boot_loader_pkg::*;
#(
    parameter int IM_SIZE_BIT    = 8,
    parameter int DM_SIZE_BIT    = 9,
    parameter int MAX_SIZE_BIT   = 9,
    parameter int FIFO_DEPTH     = 4,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_valid,
    input  logic                    ld_ram_id,
    input  logic [MAX_SIZE_BIT-1:0] ld_addr,
    input  logic [31:0]             ld_data,
    input  logic                    im_done,
    input  logic                    dm_done,
    input  logic                    cpu_dm_we,
    output logic                    im_we,
    output logic                    dm_we,
    output logic [MAX_SIZE_BIT-1:0] mem_waddr,
    output logic [31:0]             mem_wdata,
    output logic                    cpu_rst_n,
    output logic                    boot_done,
    output logic [2:0]              err_flags,
    output logic [31:0]             checksum
);

    localparam int EW    = fifo_entry_width(MAX_SIZE_BIT);
    localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

    if (MAX_SIZE_BIT < IM_SIZE_BIT || MAX_SIZE_BIT < DM_SIZE_BIT ||
        FIFO_DEPTH < 2 || RELEASE_CYCLES < 1) begin : g_bad_cfg
        $error("boot_mem_loader: invalid parameter combination");
    end

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [EW-1:0]           push_entry_s, head_entry_s;
    logic                    fifo_empty_s, fifo_full_s;
    logic                    push_s, pop_s, port_ok_s;
    logic                    rej_late_s, rej_range_s, rej_ovf_s;
    logic                    head_ram_id_s;
    logic [MAX_SIZE_BIT-1:0] head_addr_s;
    logic [31:0]             head_data_s;

    logic                    im_we_q, im_we_d;
    logic                    dm_we_q, dm_we_d;
    logic [MAX_SIZE_BIT-1:0] waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    cpu_rst_n_q, cpu_rst_n_d;
    logic                    boot_done_q, boot_done_d;
    logic [2:0]              err_q, err_d;

    assign push_entry_s = {ld_ram_id, ld_addr, ld_data};
    assign {head_ram_id_s, head_addr_s, head_data_s} = head_entry_s;

    boot_word_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .wr_data_i (push_entry_s),
        .rd_data_o (head_entry_s),
        .empty_o   (fifo_empty_s),
        .full_o    (fifo_full_s)
    );

    // Pop is decided first so a full FIFO can still accept a word in a pop cycle.
    always_comb begin
        if (state_q == ST_RUN && head_ram_id_s && cpu_dm_we) begin
            port_ok_s = 1'b0;
        end else begin
            port_ok_s = 1'b1;
        end
        pop_s       = !fifo_empty_s && port_ok_s;
        rej_late_s  = ld_valid && (state_q == ST_RUN);
        rej_range_s = ld_valid && !rej_late_s && !ld_ram_id &&
                      ((ld_addr >> IM_SIZE_BIT) != '0);
        rej_ovf_s   = ld_valid && !rej_late_s && !rej_range_s &&
                      fifo_full_s && !pop_s;
        push_s      = ld_valid && !rej_late_s && !rej_range_s && !rej_ovf_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any word entering or waiting during RELEASE restarts the release count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (im_done && dm_done) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s && !push_s) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RELEASE: begin
                if (!fifo_empty_s || push_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        im_we_d     = pop_s && !head_ram_id_s;
        dm_we_d     = pop_s && head_ram_id_s;
        if (pop_s) begin
            waddr_d = head_addr_s;
            wdata_d = head_data_s;
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
        cpu_rst_n_d = (state_d == ST_RUN);
        boot_done_d = (state_d == ST_RUN);
        err_d                 = err_q;
        err_d[ERR_LATE]       = err_q[ERR_LATE] | rej_late_s;
        err_d[ERR_ADDR_RANGE] = err_q[ERR_ADDR_RANGE] | rej_range_s;
        err_d[ERR_OVERFLOW]   = err_q[ERR_OVERFLOW] | rej_ovf_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'd0;
            cpu_rst_n_q <= 1'b0;
            boot_done_q <= 1'b0;
            err_q       <= 3'b000;
        end else begin
            im_we_q     <= im_we_d;
            dm_we_q     <= dm_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            boot_done_q <= boot_done_d;
            err_q       <= err_d;
        end
    end

    assign im_we     = im_we_q;
    assign dm_we     = dm_we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign boot_done = boot_done_q;
    assign err_flags = err_q;

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 32'd0;
        end else if (push_s && state_q != ST_RUN) begin
            csum_q <= csum_q + ld_data;
        end else begin
            csum_q <= csum_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_boot_mem_loader.sv
// Self-checking bench for boot_mem_loader: vector table for the load phase,
// scoreboard of expected memory writes, hand sequences for release/reset corners.
module tb_boot_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, ld_ram_id, im_done, dm_done, cpu_dm_we;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;
    logic        im_we, dm_we, cpu_rst_n, boot_done;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata, checksum;
    logic [2:0]  err_flags;

    always #5 clk = ~clk;

    boot_mem_loader #(
        .IM_SIZE_BIT(8), .DM_SIZE_BIT(9), .MAX_SIZE_BIT(9),
        .FIFO_DEPTH(4), .RELEASE_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ram_id(ld_ram_id),
        .ld_addr(ld_addr), .ld_data(ld_data), .im_done(im_done), .dm_done(dm_done),
        .cpu_dm_we(cpu_dm_we), .im_we(im_we), .dm_we(dm_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .boot_done(boot_done),
        .err_flags(err_flags), .checksum(checksum)
    );

    typedef struct {
        logic        ram_id;
        logic [8:0]  addr;
        logic [31:0] data;
        logic        exp_wr;
        logic [2:0]  exp_err;
    } vec_t;

    typedef struct {
        logic        dm;
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t        vecs [7];
    wr_t         exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_csum = 32'd0;
    int          n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] csum_expect();
`ifdef BOOT_CHECKSUM_EN
        return exp_csum;
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && (im_we || dm_we)) begin
            check("one_we_only", {62'd0, im_we, dm_we} == 64'd3, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {im_we, dm_we, mem_waddr, mem_wdata}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("write", {im_we, dm_we, mem_waddr, mem_wdata},
                      {!e.dm, e.dm, e.addr, e.data});
            end
        end
    end

    task automatic drive(input logic ram, input logic [8:0] addr, input logic [31:0] data,
                         input logic exp_wr);
        wr_t e;
        @(negedge clk);
        ld_valid  = 1'b1;
        ld_ram_id = ram;
        ld_addr   = addr;
        ld_data   = data;
        if (exp_wr) begin
            e.dm = ram; e.addr = addr; e.data = data;
            exp_q.push_back(e);
            exp_csum = exp_csum + data;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_ram_id = 1'b0; ld_addr = 9'd0;
        ld_data = 32'd0; im_done = 1'b0; dm_done = 1'b0; cpu_dm_we = 1'b0;

        vecs[0] = '{1'b0, 9'h000, 32'h11111111, 1'b1, 3'b000};
        vecs[1] = '{1'b0, 9'h001, 32'h22222222, 1'b1, 3'b000};
        vecs[2] = '{1'b0, 9'h100, 32'h33333333, 1'b0, 3'b010};
        vecs[3] = '{1'b1, 9'h100, 32'hFFFFFFFF, 1'b1, 3'b010};
        vecs[4] = '{1'b1, 9'h1FF, 32'h00000002, 1'b1, 3'b010};
        vecs[5] = '{1'b0, 9'h0FF, 32'hA5A5A5A5, 1'b1, 3'b010};
        vecs[6] = '{1'b0, 9'h1FF, 32'h5A5A5A5A, 1'b0, 3'b010};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {im_we, dm_we, mem_waddr, mem_wdata, cpu_rst_n, boot_done, err_flags}, 64'd0);
        check("reset_checksum", checksum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].ram_id, vecs[i].addr, vecs[i].data, vecs[i].exp_wr);
            idle();
            check($sformatf("vec%0d_err", i), err_flags, vecs[i].exp_err);
            check($sformatf("vec%0d_cpu_rst", i), cpu_rst_n, 1'b0);
        end

        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 9'h010 + 9'(k), 32'hC0DE0000 + 32'(k), 1'b1);
        end
        idle();
        repeat (3) @(negedge clk);
        check("b2b_no_overflow", err_flags, 3'b010);
        check("b2b_all_written", exp_q.size(), 64'd0);
        check("load_checksum", checksum, csum_expect());

        @(negedge clk);
        im_done = 1'b1; dm_done = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++; #1;
            if (cpu_rst_n) break;
            check("boot_done_low_before_run", boot_done, 1'b0);
        end
        check("release_latency", n, 18);
        check("boot_done_run", boot_done, 1'b1);

        cpu_dm_we = 1'b1;
        drive(1'b1, 9'h004, 32'hDEADBEEF, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        check("late_flag", err_flags, 3'b110);
        check("run_checksum_frozen", checksum, csum_expect());
        cpu_dm_we = 1'b0;

        @(negedge clk);
        rst_n = 1'b0; im_done = 1'b0; dm_done = 1'b0;
        exp_q.delete(); exp_csum = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        im_done = 1'b1; dm_done = 1'b1;
        drive(1'b0, 9'h030, 32'h00000030, 1'b1);
        drive(1'b0, 9'h031, 32'h00000031, 1'b1);
        drive(1'b1, 9'h032, 32'h00000032, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {im_we, dm_we, mem_waddr, mem_wdata, cpu_rst_n, boot_done, err_flags}, 64'd0);
        check("rst_async_checksum", checksum, 64'd0);
        exp_q.delete(); exp_csum = 32'd0;
        ld_valid = 1'b0; im_done = 1'b0; dm_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_err", err_flags, 3'b000);
        check("post_reset_cpu_rst", cpu_rst_n, 1'b0);

        drive(1'b1, 9'h020, 32'hFFFFFFFF, 1'b1);
        drive(1'b1, 9'h021, 32'h00000002, 1'b1);
        idle();
        repeat (3) @(negedge clk);
`ifdef BOOT_CHECKSUM_EN
        check("checksum_wrap", checksum, 32'h00000001);
`else
        check("checksum_tied", checksum, 32'h00000000);
`endif

        @(negedge clk);
        im_done = 1'b1; dm_done = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++; #1;
            if (cpu_rst_n) break;
            @(negedge clk);
            if (n == 5) begin
                drive_now();
            end else begin
                ld_valid = 1'b0;
            end
        end
        ld_valid = 1'b0;
        check("release_delayed", (n > 18) && (n < 100), 1'b1);
        check("release_word_err", err_flags, 3'b000);
        check("release_checksum", checksum, csum_expect());
        repeat (2) @(negedge clk);
        check("all_writes_seen", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic drive_now();
        wr_t e;
        ld_valid  = 1'b1;
        ld_ram_id = 1'b0;
        ld_addr   = 9'h0AA;
        ld_data   = 32'h600DF00D;
        e.dm = 1'b0; e.addr = 9'h0AA; e.data = 32'h600DF00D;
        exp_q.push_back(e);
        exp_csum = exp_csum + 32'h600DF00D;
    endtask

endmodule
